// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types, defaults and width helper for the serial-to-parallel receiver
package s2p_pkg;
  typedef enum logic {HUNT, SHIFT} state_t;
  localparam int W_DEF = 4;
  localparam int DEPTH_DEF = 2;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/s2p_fifo.sv
// s2p_fifo: small synchronous FIFO whose head word and valid flag are registered
module s2p_fifo import s2p_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_drop,
  output logic [W-1:0] o_head,
  output logic         o_valid
);
  localparam int AW = cnt_w(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_full, w_wr_en;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign w_wr_en = i_push & (~w_full | i_pop);
  assign o_drop = i_push & w_full & ~i_pop;
  // storage, pointers and the registered head; a word pushed this edge shows at the head one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      o_head <= '0;
      o_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr_en) - (AW+1)'(i_pop);
      o_valid <= (r_cnt - (AW+1)'(i_pop)) != '0;
      o_head <= r_mem[r_rd + AW'(i_pop)];
    end
  end
endmodule

// File: rtl/serial2parallel_rx.sv
// serial2parallel_rx: frames an MSB-first serial stream into words, queues them, tracks framing and overflow faults
module serial2parallel_rx import s2p_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_sync,
  output logic [W-1:0]         m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] sync_err_cnt,
  input  logic                 clr_err
);
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W-1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [W-2:0] r_shift;
  logic r_ovf;
  logic [ERR_CNT_W-1:0] r_err;
  logic w_err, w_push, w_pop, w_drop;
  assign w_err = din_sync & (r_state == SHIFT);
  assign w_push = (r_state == SHIFT) & ~din_sync & (r_cnt == LAST);
  assign w_pop = m_valid & m_ready;
  assign overflow = r_ovf;
  assign sync_err_cnt = r_err;
  // framer: any sync restarts capture, otherwise shift until the last bit completes the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_cnt <= '0;
      r_shift <= '0;
    end else if (din_sync) begin
      r_state <= SHIFT;
      r_cnt <= CW'(1);
      r_shift <= (W-1)'(din);
    end else if (r_state == SHIFT) begin
      r_state <= (r_cnt == LAST) ? HUNT : SHIFT;
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_shift <= (W-1)'({r_shift, din});
    end
  end
  // sticky overflow and saturating sync-error count; a clear beats a same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_err <= '0;
    end else begin
      r_ovf <= clr_err ? 1'b0 : (r_ovf | w_drop);
      r_err <= clr_err ? '0 : r_err + ERR_CNT_W'(w_err && r_err != '1);
    end
  end
  s2p_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_push),
    .i_data({r_shift, din}),
    .i_pop(w_pop),
    .o_drop(w_drop),
    .o_head(m_data),
    .o_valid(m_valid)
  );
endmodule

// File: tb/tb_serial2parallel_rx.sv
// tb_serial2parallel_rx: directed and randomized checks of the receiver against a frame-level model
module tb_serial2parallel_rx;
  logic clk = 1'b0;
  logic rst_n, din, din_sync, m_ready, clr_err;
  logic [3:0] m_data;
  logic m_valid, overflow;
  logic [7:0] sync_err_cnt;
  int tests = 0;
  int fails = 0;
  logic [3:0] got[$];
  logic [3:0] exp_q[$];
  int aborts;
  logic [3:0] w;

  serial2parallel_rx #(.W(4), .DEPTH(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_sync(din_sync),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .sync_err_cnt(sync_err_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // record every completed transfer as the consumer sees it
  always @(negedge clk) if (rst_n && m_valid && m_ready) got.push_back(m_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic d, input logic s);
    din = d;
    din_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'($urandom), 1'b0);
  endtask

  task automatic send_word(input logic [3:0] x);
    for (int i = 3; i >= 0; i--) cyc(x[i], i == 3);
  endtask

  task automatic chk_got(input string tag, input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2, input int n);
    logic [3:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_sync = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(sync_err_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);
    // single frame: word appears one edge after the last bit
    m_ready = 1'b1;
    send_word(4'hB);
    chk("single_latency", 32'(m_valid), 32'd0);
    cyc(1'b0, 1'b0);
    chk("single_valid", 32'(m_valid), 32'd1);
    chk("single_data", 32'(m_data), 32'hB);
    cyc(1'b0, 1'b0);
    chk("single_drained", 32'(m_valid), 32'd0);
    chk_got("single", 4'hB, 4'h0, 4'h0, 1);
    // back-to-back frames with no dead cycles
    send_word(4'hB); send_word(4'h6); send_word(4'hF);
    idle(3);
    chk_got("b2b", 4'hB, 4'h6, 4'hF, 3);
    chk("b2b_err", 32'(sync_err_cnt), 32'd0);
    // overflow with a stalled consumer
    m_ready = 1'b0;
    send_word(4'h1); send_word(4'h2); send_word(4'h3);
    idle(2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(m_data), 32'h1);
    m_ready = 1'b1;
    idle(5);
    chk_got("ovf_drain", 4'h1, 4'h2, 4'h0, 2);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1'b1; cyc(1'b0, 1'b0); clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    // mid-frame sync discards the partial word
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
    send_word(4'hA);
    idle(3);
    chk_got("midsync", 4'hA, 4'h0, 4'h0, 1);
    chk("midsync_err", 32'(sync_err_cnt), 32'd1);
    // clear beats a simultaneous event
    cyc(1'b1, 1'b1);
    clr_err = 1'b1; cyc(1'b0, 1'b1); clr_err = 1'b0;
    chk("clr_wins", 32'(sync_err_cnt), 32'd0);
    repeat (255) cyc(1'($urandom), 1'b1);
    chk("err_255", 32'(sync_err_cnt), 32'd255);
    cyc(1'b0, 1'b1);
    chk("err_sat", 32'(sync_err_cnt), 32'd255);
    idle(6);
    got.delete();
    clr_err = 1'b1; cyc(1'b0, 1'b0); clr_err = 1'b0;
    // asynchronous reset mid-frame with a word queued
    m_ready = 1'b0;
    send_word(4'h9);
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_data", 32'(m_data), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_word(4'h5);
    idle(3);
    chk_got("post_rst", 4'h5, 4'h0, 4'h0, 1);
    // push while full with a same-cycle pop
    m_ready = 1'b0;
    send_word(4'h1); send_word(4'h2);
    cyc(1'b0, 1'b0);
    w = 4'h3;
    for (int i = 3; i >= 0; i--) begin
      m_ready = (i == 0);
      cyc(w[i], i == 3);
    end
    m_ready = 1'b0;
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_valid", 32'(m_valid), 32'd1);
    chk("fullpop_head", 32'(m_data), 32'h2);
    m_ready = 1'b1;
    idle(6);
    chk_got("fullpop", 4'h1, 4'h2, 4'h3, 3);
    // randomized frames with random gaps and aborted partial frames
    clr_err = 1'b1; cyc(1'b0, 1'b0); clr_err = 1'b0;
    aborts = 0;
    for (int n = 0; n < 40; n++) begin
      w = 4'($urandom);
      if ($urandom_range(3) == 0) begin
        for (int j = 0; j < int'($urandom_range(3, 1)); j++) cyc(1'($urandom), j == 0);
        aborts++;
      end else idle(int'($urandom_range(3)));
      send_word(w);
      exp_q.push_back(w);
    end
    idle(4);
    chk("rand_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("rand_word", 32'(got[i]), 32'(exp_q[i]));
    chk("rand_err", 32'(sync_err_cnt), 32'(aborts));
    chk("rand_ovf", 32'(overflow), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
